// File: rtl/phase_gate_stream.sv
// phase_gate_stream
// Applies a single-qubit diagonal phase gate to a streamed state vector.
// Amplitudes arrive in index order, N = 2^NUM_QUBITS per frame. Amplitudes
// whose index has the target bit set are multiplied by the gate's phase
// factor. All other amplitudes pass through unchanged.
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   in_valid/in_ready        input handshake
//   in_last                  frame marker, compared against the index counter
//   in_real/in_imag          input amplitude (signed, FRAC fractional bits)
//   cfg_mode/cfg_target      gate select and target qubit, sampled at idx 0
//   cfg_cos/cfg_sin          custom phase coefficients (mode 6)
//   out_valid/out_ready      output handshake
//   out_last                 asserted with the output of amplitude N-1
//   out_real/out_imag        rotated amplitude
//   frame_err                sticky: in_last disagreed with the index counter
//
// Handshake: a beat moves when valid && ready. Once out_valid is high, the
// beat and its data stay stable until out_ready takes it. The 3-stage
// pipeline advances as a unit when !out_valid || out_ready. in_ready is
// exactly that condition.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module phase_gate_stream #(
    parameter int WIDTH      = `FIXED_WIDTH,
    parameter int FRAC       = WIDTH - 2,
    parameter int NUM_QUBITS = 4,
    localparam int TW        = (NUM_QUBITS > 1) ? $clog2(NUM_QUBITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic signed [WIDTH-1:0] in_real,
    input  logic signed [WIDTH-1:0] in_imag,
    input  logic [2:0]              cfg_mode,
    input  logic [TW-1:0]           cfg_target,
    input  logic signed [WIDTH-1:0] cfg_cos,
    input  logic signed [WIDTH-1:0] cfg_sin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic signed [WIDTH-1:0] out_real,
    output logic signed [WIDTH-1:0] out_imag,
    output logic                    frame_err
);

    typedef enum logic [2:0] {
        MODE_I      = 3'd0,
        MODE_Z      = 3'd1,
        MODE_S      = 3'd2,
        MODE_SDG    = 3'd3,
        MODE_T      = 3'd4,
        MODE_TDG    = 3'd5,
        MODE_CUSTOM = 3'd6,
        MODE_RSVD   = 3'd7
    } mode_t;

    // Coefficients carry one extra bit so that +1.0 is representable even
    // when FRAC = WIDTH-1. Every gate is then a complex multiply, and the
    // negation/swap gates round and saturate exactly like T and custom.
    localparam int CW = WIDTH + 1;
    localparam int PW = WIDTH + CW;
    localparam int SW = PW + 1;

    localparam real                   T_REAL = (2.0 ** FRAC) / 1.4142135623730951;
    localparam logic signed [CW-1:0] C_ONE  = CW'(1) << FRAC;
    localparam logic signed [CW-1:0] C_T    = CW'($rtoi(T_REAL + 0.5));
    localparam logic signed [SW-1:0] HALF_S = SW'(1) << (FRAC - 1);
    localparam logic signed [SW-1:0] MAX_S  = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_S  = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > MAX_S)      return MAX_S[WIDTH-1:0];
        else if (v < MIN_S) return MIN_S[WIDTH-1:0];
        else                return v[WIDTH-1:0];
    endfunction

    logic                    adv;
    logic                    accept;
    logic [NUM_QUBITS-1:0]   idx;
    logic                    at_start;
    logic                    at_end;

    mode_t                   lat_mode;
    logic [TW-1:0]           lat_target;
    logic signed [WIDTH-1:0] lat_cos;
    logic signed [WIDTH-1:0] lat_sin;

    mode_t                   eff_mode;
    logic [TW-1:0]           eff_target;
    logic signed [WIDTH-1:0] eff_cos;
    logic signed [WIDTH-1:0] eff_sin;
    logic [NUM_QUBITS-1:0]   idx_shift;
    logic signed [CW-1:0]    coef_re;
    logic signed [CW-1:0]    coef_im;

    logic                    s1_valid, s1_last;
    logic signed [WIDTH-1:0] s1_re, s1_im;
    logic signed [CW-1:0]    s1_cr, s1_ci;

    logic                    s2_valid, s2_last;
    logic signed [PW-1:0]    p_ac, p_bd, p_ad, p_bc;

    logic signed [SW-1:0]    sum_re, sum_im;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && in_ready;
    assign at_start = (idx == '0);
    assign at_end   = (idx == '1);

    // The idx-0 beat uses the live cfg inputs, so a new frame's gate is
    // applied to its first amplitude with no bubble. All later beats use
    // the copy latched on that beat.
    always_comb begin
        eff_mode   = lat_mode;
        eff_target = lat_target;
        eff_cos    = lat_cos;
        eff_sin    = lat_sin;
        if (at_start) begin
            eff_mode   = (int'(cfg_target) >= NUM_QUBITS) ? MODE_I : mode_t'(cfg_mode);
            eff_target = cfg_target;
            eff_cos    = cfg_cos;
            eff_sin    = cfg_sin;
        end
    end

    always_comb begin
        idx_shift = idx >> eff_target;
        coef_re   = C_ONE;
        coef_im   = '0;
        if (idx_shift[0]) begin
            case (eff_mode)
                MODE_Z:      begin coef_re = -C_ONE; coef_im = '0;     end
                MODE_S:      begin coef_re = '0;     coef_im = C_ONE;  end
                MODE_SDG:    begin coef_re = '0;     coef_im = -C_ONE; end
                MODE_T:      begin coef_re = C_T;    coef_im = C_T;    end
                MODE_TDG:    begin coef_re = C_T;    coef_im = -C_T;   end
                MODE_CUSTOM: begin coef_re = CW'(eff_cos); coef_im = CW'(eff_sin); end
                default:     begin coef_re = C_ONE;  coef_im = '0;     end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            frame_err  <= 1'b0;
            lat_mode   <= MODE_I;
            lat_target <= '0;
            lat_cos    <= '0;
            lat_sin    <= '0;
        end else if (accept) begin
            // No resync on a framing error: the counter keeps its normal wrap.
            idx <= idx + 1'b1;
            if (in_last != at_end) frame_err <= 1'b1;
            if (at_start) begin
                lat_mode   <= eff_mode;
                lat_target <= eff_target;
                lat_cos    <= eff_cos;
                lat_sin    <= eff_sin;
            end
        end
    end

    // Stage 1: operand and coefficient capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s1_cr    <= '0;
            s1_ci    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_valid && at_end;
            s1_re    <= in_real;
            s1_im    <= in_imag;
            s1_cr    <= coef_re;
            s1_ci    <= coef_im;
        end
    end

    // Stage 2: the four partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            p_ac     <= '0;
            p_bd     <= '0;
            p_ad     <= '0;
            p_bc     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            p_ac     <= PW'(s1_re) * PW'(s1_cr);
            p_bd     <= PW'(s1_im) * PW'(s1_ci);
            p_ad     <= PW'(s1_re) * PW'(s1_ci);
            p_bc     <= PW'(s1_im) * PW'(s1_cr);
        end
    end

    // Stage 3: combine, round half up, scale back, saturate.
    always_comb begin
        sum_re = ((SW'(p_ac) - SW'(p_bd)) + HALF_S) >>> FRAC;
        sum_im = ((SW'(p_ad) + SW'(p_bc)) + HALF_S) >>> FRAC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_last  <= s2_last;
            out_real  <= sat(sum_re);
            out_imag  <= sat(sum_im);
        end
    end

endmodule

// File: tb/tb_phase_gate_stream.sv
// Directed bench for phase_gate_stream (WIDTH=16, FRAC=14, NUM_QUBITS=2).
// Expected outputs are hand-computed words {last, real, imag} queued in
// order. A monitor pops the queue on each output transfer, checks 3-cycle
// latency when enabled, and checks that outputs hold during stalls.

module tb_phase_gate_stream;

    localparam int WIDTH = 16;
    localparam int FRAC  = 14;
    localparam int NQ    = 2;
    localparam int TO    = 200;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    logic signed [WIDTH-1:0] in_real;
    logic signed [WIDTH-1:0] in_imag;
    logic [2:0]              cfg_mode;
    logic                    cfg_target;
    logic signed [WIDTH-1:0] cfg_cos;
    logic signed [WIDTH-1:0] cfg_sin;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic signed [WIDTH-1:0] out_real;
    logic signed [WIDTH-1:0] out_imag;
    logic                    frame_err;

    phase_gate_stream #(.WIDTH(WIDTH), .FRAC(FRAC), .NUM_QUBITS(NQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .cfg_mode   (cfg_mode),
        .cfg_target (cfg_target),
        .cfg_cos    (cfg_cos),
        .cfg_sin    (cfg_sin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .frame_err  (frame_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [2*WIDTH:0] exp_q[$];
    int               acc_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic             rand_rdy = 1'b0;
    logic             chk_lat  = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [2*WIDTH:0] ew(input logic l, input int re, input int im);
        return {l, 16'(re), 16'(im)};
    endfunction

    // out_ready changes at negedge+2, the driver acts at negedge+3 and the
    // monitor samples at negedge+4, all before the next rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic             hold_pend;
        logic [2*WIDTH:0] hold_val;
        logic [2*WIDTH:0] e;
        int               a;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", longint'(out_valid), 1);
                    check("hold_data", longint'({out_last, out_real, out_imag}), longint'(hold_val));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", longint'({out_last, out_real, out_imag}), -1);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("out_beat", longint'({out_last, out_real, out_imag}), longint'(e));
                        if (chk_lat) check("latency", longint'(cyc - a), 3);
                    end
                end
                hold_pend = out_valid && !out_ready;
                hold_val  = {out_last, out_real, out_imag};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int re, input int im, input logic last,
                        input logic [2:0] mode, input logic tgt,
                        input int cs, input int sn, input logic [2*WIDTH:0] e);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        #3;
        in_valid   = 1'b1;
        in_real    = 16'(re);
        in_imag    = 16'(im);
        in_last    = last;
        cfg_mode   = mode;
        cfg_target = tgt;
        cfg_cos    = 16'(cs);
        cfg_sin    = 16'(sn);
        for (int t = 0; t < TO; t++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #3;
        end
        if (!ok) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        #3;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < TO; t++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", longint'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_real    = '0;
        in_imag    = '0;
        cfg_mode   = 3'd0;
        cfg_target = 1'b0;
        cfg_cos    = '0;
        cfg_sin    = '0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_last",  longint'(out_last), 0);
        check("rst_frame_err", longint'(frame_err), 0);
        check("rst_in_ready",  longint'(in_ready), 1);
        check("rst_out_data",  longint'({out_real, out_imag}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // S on target 0. Mid-frame cfg shows Z, which must be ignored.
        chk_lat = 1'b1;
        send(1000, 2000, 1'b0, 3'd2, 1'b0, 0, 0, ew(1'b0, 1000, 2000));
        send(1000, 2000, 1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, -2000, 1000));
        send(1000, 2000, 1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, 1000, 2000));
        send(1000, 2000, 1'b1, 3'd1, 1'b1, 0, 0, ew(1'b1, -2000, 1000));
        idle();
        drain();
        chk_lat = 1'b0;
        check("err_after_s", longint'(frame_err), 0);

        // T on target 1.
        send(16384, 0, 1'b0, 3'd4, 1'b1, 0, 0, ew(1'b0, 16384, 0));
        send(16384, 0, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 16384, 0));
        send(16384, 0, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 11585, 11585));
        send(0, 16384, 1'b1, 3'd0, 1'b0, 0, 0, ew(1'b1, -11585, 11585));
        // Z on target 1 with saturating negation.
        send(-32768, 100, 1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, -32768, 100));
        send(5, -7,       1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, 5, -7));
        send(-32768, 100, 1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, 32767, -100));
        send(-1, 1,       1'b1, 3'd1, 1'b1, 0, 0, ew(1'b1, 1, -1));
        // Custom phase cos=0, sin=1.0 on target 0.
        send(-32768, 0, 1'b0, 3'd6, 1'b0, 0, 16384, ew(1'b0, -32768, 0));
        send(-32768, 0, 1'b0, 3'd6, 1'b0, 0, 0,     ew(1'b0, 0, -32768));
        send(3, 4,      1'b0, 3'd6, 1'b0, 0, 0,     ew(1'b0, 3, 4));
        send(100, -50,  1'b1, 3'd6, 1'b0, 0, 0,     ew(1'b1, 50, 100));
        idle();
        drain();
        check("err_after_dir", longint'(frame_err), 0);

        // Three back-to-back frames under random backpressure.
        rand_rdy = 1'b1;
        send(100, 200,  1'b0, 3'd3, 1'b1, 0, 0, ew(1'b0, 100, 200));
        send(300, -400, 1'b0, 3'd2, 1'b0, 0, 0, ew(1'b0, 300, -400));
        send(500, 600,  1'b0, 3'd2, 1'b0, 0, 0, ew(1'b0, 600, -500));
        send(-700, 800, 1'b1, 3'd2, 1'b0, 0, 0, ew(1'b1, 800, 700));
        send(100, 200,     1'b0, 3'd5, 1'b0, 0, 0, ew(1'b0, 100, 200));
        send(16384, 16384, 1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, 23170, 0));
        send(7, 8,         1'b0, 3'd1, 1'b1, 0, 0, ew(1'b0, 7, 8));
        send(0, -16384,    1'b1, 3'd1, 1'b1, 0, 0, ew(1'b1, -11585, -11585));
        send(1, 2,         1'b0, 3'd7, 1'b1, 0, 0, ew(1'b0, 1, 2));
        send(3, 4,         1'b0, 3'd1, 1'b0, 0, 0, ew(1'b0, 3, 4));
        send(-5, -6,       1'b0, 3'd1, 1'b0, 0, 0, ew(1'b0, -5, -6));
        send(32767, -32768, 1'b1, 3'd1, 1'b0, 0, 0, ew(1'b1, 32767, -32768));
        idle();
        drain();
        rand_rdy = 1'b0;
        check("err_after_rand", longint'(frame_err), 0);

        // Early in_last sets the sticky error, then reset mid-frame.
        send(1, 1, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 1, 1));
        send(2, 2, 1'b1, 3'd0, 1'b0, 0, 0, ew(1'b0, 2, 2));
        #1;
        check("err_early_last", longint'(frame_err), 1);
        send(3, 3, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 3, 3));
        #1;
        check("err_sticky", longint'(frame_err), 1);
        check("pre_rst_valid", longint'(out_valid), 1);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid), 0);
        check("midrst_frame_err", longint'(frame_err), 0);
        check("midrst_in_ready",  longint'(in_ready), 1);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Z on target 0 shows that the frame restarts at idx 0.
        send(11, 12, 1'b0, 3'd1, 1'b0, 0, 0, ew(1'b0, 11, 12));
        send(11, 12, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, -11, -12));
        send(11, 12, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 11, 12));
        send(11, 12, 1'b1, 3'd0, 1'b0, 0, 0, ew(1'b1, -11, -12));
        idle();
        drain();
        check("err_after_restart", longint'(frame_err), 0);

        // Missing in_last on idx N-1; out_last still follows the counter.
        send(9, 9, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 9, 9));
        send(9, 9, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 9, 9));
        send(9, 9, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b0, 9, 9));
        send(9, 9, 1'b0, 3'd0, 1'b0, 0, 0, ew(1'b1, 9, 9));
        idle();
        drain();
        check("err_missing_last", longint'(frame_err), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
